// File: rtl/fmpad_pkg.sv
// Shared sizing helpers and the pad-region predicate for the feature-map padder.
package fmpad_pkg;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned out_dim(input int unsigned img, input int unsigned pad_a,
                                            input int unsigned pad_b);
        return img + pad_a + pad_b;
    endfunction

    function automatic int unsigned frame_words(input int unsigned out_h, input int unsigned out_w,
                                                input int unsigned fold);
        return out_h * out_w * fold;
    endfunction

    // True when padded-map position (y, x) lies outside the unpadded image.
    function automatic bit in_pad(input int unsigned y, input int unsigned x,
                                  input int unsigned pad_t, input int unsigned img_h,
                                  input int unsigned pad_l, input int unsigned img_w);
        return (y < pad_t) || (y >= pad_t + img_h) || (x < pad_l) || (x >= pad_l + img_w);
    endfunction

endpackage

// File: rtl/fmpad_output_stage.sv
// One-deep AXI-stream register: accepts a source or pad word whenever its slot is free.
module fmpad_output_stage
    import fmpad_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pad,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          slot_free_c,
    output logic          load_c,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    assign slot_free_c = !out_valid || out_ready;
    assign load_c      = slot_free_c && (pad || in_valid);

    // A load in the same cycle as a handshake replaces the word with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_data  <= pad ? '0 : in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fm_padding_generator.sv
// Streaming zero-padder: walks the padded map position by position and inserts
// zero words at border positions while passing interior words from the source.
module fm_padding_generator
    import fmpad_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned SIMD      = 1,
    parameter int unsigned FOLD      = 13,
    parameter int unsigned IMG_H     = 10,
    parameter int unsigned IMG_W     = 10,
    parameter int unsigned PAD_T     = 1,
    parameter int unsigned PAD_B     = 1,
    parameter int unsigned PAD_L     = 1,
    parameter int unsigned PAD_R     = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in0_V_V_TVALID,
    output logic                      in0_V_V_TREADY,
    input  logic [BIT_WIDTH*SIMD-1:0] in0_V_V_TDATA,
    output logic                      out_V_V_TVALID,
    input  logic                      out_V_V_TREADY,
    output logic [BIT_WIDTH*SIMD-1:0] out_V_V_TDATA
);

    localparam int unsigned DW    = BIT_WIDTH * SIMD;
    localparam int unsigned OUT_W = out_dim(IMG_W, PAD_L, PAD_R);
    localparam int unsigned OUT_H = out_dim(IMG_H, PAD_T, PAD_B);
    localparam int unsigned SW    = cnt_w(FOLD - 1);
    localparam int unsigned XW    = cnt_w(OUT_W - 1);
    localparam int unsigned YW    = cnt_w(OUT_H - 1);

    logic [SW-1:0] s_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          is_pad_c;
    logic          slot_free_c;
    logic          load_c;

    assign is_pad_c       = in_pad(32'(y_q), 32'(x_q), PAD_T, IMG_H, PAD_L, IMG_W);
    assign in0_V_V_TREADY = ap_rst_n && slot_free_c && !is_pad_c;

    // Position of the next word to load; fold innermost, then column, then row.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (load_c) begin
            if (s_q == SW'(FOLD - 1)) begin
                s_q <= '0;
                if (x_q == XW'(OUT_W - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == YW'(OUT_H - 1)) ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end else begin
                s_q <= s_q + SW'(1);
            end
        end
    end

    fmpad_output_stage #(
        .DW(DW)
    ) u_out (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .pad        (is_pad_c),
        .in_valid   (in0_V_V_TVALID),
        .in_data    (in0_V_V_TDATA),
        .out_ready  (out_V_V_TREADY),
        .slot_free_c(slot_free_c),
        .load_c     (load_c),
        .out_valid  (out_V_V_TVALID),
        .out_data   (out_V_V_TDATA)
    );

endmodule

// File: tb/tb_fm_padding_generator.sv
// Bench for fm_padding_generator: default 10x10x13 map with 1-pixel border,
// plus a pad-free 4x4x2 instance behaving as a plain register slice.
module tb_fm_padding_generator;
    import fmpad_pkg::*;

    localparam int unsigned FOLD  = 13;
    localparam int unsigned IMG   = 10;
    localparam int unsigned OW    = 12;
    localparam int unsigned OH    = 12;
    localparam int unsigned IN_FR = IMG * IMG * FOLD;

    logic       ap_clk, ap_rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic       z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [7:0] z_in_data, z_out_data;

    fm_padding_generator #(
        .BIT_WIDTH(8), .SIMD(1), .FOLD(FOLD), .IMG_H(IMG), .IMG_W(IMG),
        .PAD_T(1), .PAD_B(1), .PAD_L(1), .PAD_R(1)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in0_V_V_TVALID(in_valid), .in0_V_V_TREADY(in_ready), .in0_V_V_TDATA(in_data),
        .out_V_V_TVALID(out_valid), .out_V_V_TREADY(out_ready), .out_V_V_TDATA(out_data)
    );

    fm_padding_generator #(
        .BIT_WIDTH(8), .SIMD(1), .FOLD(2), .IMG_H(4), .IMG_W(4),
        .PAD_T(0), .PAD_B(0), .PAD_L(0), .PAD_R(0)
    ) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in0_V_V_TVALID(z_in_valid), .in0_V_V_TREADY(z_in_ready), .in0_V_V_TDATA(z_in_data),
        .out_V_V_TVALID(z_out_valid), .out_V_V_TREADY(z_out_ready), .out_V_V_TDATA(z_out_data)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        int idx;
        int exp;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] exp_q[$];
    logic [7:0] cap[6000];
    int         n_vec, n_err;
    int         src_idx, frames_pushed, out_cnt, rdy_cnt, bub_cnt;
    bit         stall_prev;
    logic [7:0] stall_data;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output words for one full padded frame.
    task automatic push_frame();
        int k;
        k = 0;
        for (int y = 0; y < int'(OH); y++)
            for (int x = 0; x < int'(OW); x++)
                for (int s = 0; s < int'(FOLD); s++)
                    if (in_pad(y, x, 1, IMG, 1, IMG)) exp_q.push_back(8'd0);
                    else begin
                        exp_q.push_back(8'(frames_pushed * int'(IN_FR) + k));
                        k++;
                    end
        frames_pushed++;
    endtask

    task automatic sb_reset();
        exp_q.delete();
        src_idx = 0; frames_pushed = 0; out_cnt = 0;
        rdy_cnt = 0; bub_cnt = 0; stall_prev = 1'b0;
    endtask

    // One clock: drive at posedge+1, sample at negedge (handshakes happen at next posedge).
    task automatic cycle(input bit rdy, input bit vld);
        logic [7:0] e;
        out_ready = rdy;
        in_valid  = vld;
        in_data   = 8'(src_idx);
        @(negedge ap_clk);
        if (stall_prev) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(stall_data));
        end
        if (!out_valid) bub_cnt++;
        if (in_ready) rdy_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) push_frame();
            e = exp_q.pop_front();
            check($sformatf("out_word[%0d]", out_cnt), int'(out_data), int'(e));
            if (out_cnt < 6000) cap[out_cnt] = out_data;
            out_cnt++;
        end
        if (in_valid && in_ready) src_idx++;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = 8'd0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_tvalid", int'(out_valid), 0);
        check("rst_tdata", int'(out_data), 0);
        check("rst_tready", int'(in_ready), 0);
        ap_rst_n = 1'b1;
        sb_reset();
    endtask

    task automatic check_table(input int limit);
        for (int i = 0; i < 16; i++)
            if (tbl[i].idx < limit)
                check($sformatf("tbl_out[%0d]", tbl[i].idx), int'(cap[tbl[i].idx]), tbl[i].exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        int gap, z_cnt;
        n_vec = 0; n_err = 0;
        ap_rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = 8'd0;
        z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_data = 8'd0;
        tbl = '{'{0, 0}, '{168, 0}, '{169, 0}, '{170, 1}, '{181, 12}, '{182, 13},
                '{298, 129}, '{299, 0}, '{1702, 19}, '{1703, 0}, '{1716, 0}, '{1871, 0},
                '{1872, 0}, '{2041, 20}, '{3913, 40}, '{5615, 0}};

        // Continuous flow over three frames.
        do_reset();
        for (int i = 0; i < 5617; i++) begin
            cycle(1'b1, 1'b1);
            if (i == 1871) check("tready_per_frame", rdy_cnt, int'(IN_FR));
        end
        check("three_frame_outputs", out_cnt, 5616);
        check_table(5616);

        // Sink ready one cycle in three.
        do_reset();
        for (int i = 0; i < 6000 && out_cnt < 1872; i++) cycle(i % 3 == 0, 1'b1);
        check("throttled_outputs", out_cnt, 1872);
        check_table(1872);

        // Source stalls for 20 cycles at input word 500.
        do_reset();
        gap = 0;
        for (int i = 0; i < 1893; i++) begin
            if (src_idx == 500 && gap < 20) begin
                gap++;
                cycle(1'b1, 1'b0);
            end else cycle(1'b1, 1'b1);
        end
        check("gap_cycles", gap, 20);
        check("gap_outputs", out_cnt, 1872);
        check("gap_bubbles", bub_cnt, 21);

        // Asynchronous reset mid-frame at output word 900.
        do_reset();
        for (int i = 0; i < 2000 && out_cnt < 900; i++) cycle(1'b1, 1'b1);
        check("pre_reset_outputs", out_cnt, 900);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", int'(out_valid), 0);
        check("async_rst_tready", int'(in_ready), 0);
        check("async_rst_tdata", int'(out_data), 0);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        sb_reset();
        for (int i = 0; i < 1873; i++) cycle(1'b1, 1'b1);
        check("post_reset_outputs", out_cnt, 1872);
        check_table(1872);

        // Pad-free instance: plain one-cycle register slice.
        in_valid = 1'b0; out_ready = 1'b0;
        z_cnt = 0; prev = 8'd0;
        for (int i = 0; i < 65; i++) begin
            z_in_valid = 1'b1;
            z_out_ready = 1'b1;
            z_in_data = 8'(i * 7 + 3);
            @(negedge ap_clk);
            check("z_tready", int'(z_in_ready), 1);
            if (i > 0) begin
                check("z_tvalid", int'(z_out_valid), 1);
                check($sformatf("z_data[%0d]", i - 1), int'(z_out_data), int'(prev));
            end
            if (z_out_valid && z_out_ready) z_cnt++;
            prev = z_in_data;
            @(posedge ap_clk);
            #1;
        end
        check("z_two_frames", z_cnt, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fm_padding_generator.md
# fm_padding_generator

Streaming feature-map padder that sits directly upstream of the sliding-window generator and drives its input stream. It consumes an unpadded IMG_H × IMG_W × (FOLD·SIMD) feature map in row-major, channel-fold-innermost order. It emits the padded (IMG_H+PAD_T+PAD_B) × (IMG_W+PAD_L+PAD_R) map in the same order, inserting all-zero SIMD words at border positions. Frames repeat back-to-back indefinitely.

## Interface
- BIT_WIDTH, 8, bits per channel element
- SIMD, 1, channel elements per stream word
- FOLD, 13, stream words per pixel (channels / SIMD)
- IMG_H, 10, unpadded height
- IMG_W, 10, unpadded width
- PAD_T / PAD_B / PAD_L / PAD_R, 1 each, border widths in pixels (0 permitted)
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- in0_V_V_TVALID  in  1  source word valid
- in0_V_V_TREADY  out  1  block accepts source word
- in0_V_V_TDATA  in  BIT_WIDTH·SIMD  source word
- out_V_V_TVALID  out  1  padded word valid
- out_V_V_TREADY  in  1  sink accepts padded word
- out_V_V_TDATA  out  BIT_WIDTH·SIMD  padded word

## Operation
- Derived constants: OUT_W = IMG_W+PAD_L+PAD_R, OUT_H = IMG_H+PAD_T+PAD_B, FRAME_WORDS = OUT_H·OUT_W·FOLD.
- Position counters: S (0..FOLD-1, innermost), X (0..OUT_W-1), Y (0..OUT_H-1). All are unsigned and sized by $clog2(max+1).
- Counters give the index of the next word to load into the output register. They advance exactly once per load:
  - S wraps at FOLD-1 and increments X.
  - X wraps at OUT_W-1 and increments Y.
  - Y wraps at OUT_H-1 to 0, which starts the next frame with no bubble.
- is_pad = (Y < PAD_T) | (Y ≥ PAD_T+IMG_H) | (X < PAD_L) | (X ≥ PAD_L+IMG_W). Comparisons are constant-bound, with no subtraction.
- Output register stage: one data register O_data and one flag O_valid.
  - slot_free = !O_valid | out_V_V_TREADY.
  - load = slot_free & (is_pad | in0_V_V_TVALID).
  - On load: O_data ← is_pad ? 0 : in0_V_V_TDATA, O_valid ← 1, and the counters advance.
  - On a successful output handshake without a load: O_valid ← 0.
- in0_V_V_TREADY = ap_rst_n & slot_free & !is_pad. The block never accepts input at a pad position.
- out_V_V_TVALID = O_valid. out_V_V_TDATA = O_data. Data is held stable while TVALID=1 and TREADY=0.
- The input word count per frame is exactly IMG_H·IMG_W·FOLD. The block does no framing check; the source must be frame-aligned.
- Reset, including when asserted mid-frame, immediately clears:
  - S, X and Y to 0
  - O_valid and O_data to 0
  - in0_V_V_TREADY to 0
  
  The first word after release is frame word 0.

## Timing
- Reset values: out_V_V_TVALID=0, out_V_V_TDATA=0, in0_V_V_TREADY=0.
- Latency is 1 cycle. A word accepted, or a pad word generated, in cycle n appears on out in cycle n+1.
- Throughput is 1 word/cycle when the sink is always ready and the source is always valid.
- in0_V_V_TREADY depends combinationally on out_V_V_TREADY and registered state only. There is no path from in0_V_V_TVALID to in0_V_V_TREADY.
- Pad words are produced without waiting on the source. A stalled source stalls output only at interior positions.
- Simultaneous output handshake and load in the same cycle: O_valid stays 1 and O_data is replaced. There is no bubble.
- Frame wrap (S=FOLD-1, X=OUT_W-1, Y=OUT_H-1) and a load in the same cycle: all counters become 0 and the next cycle evaluates is_pad for (0,0).
- All pads 0: pure 1-cycle register slice. is_pad is constant 0.

## Structure
- A shared package fmpad_pkg holds:
  - the counter-width function and derived-constant helpers (OUT_W, OUT_H, FRAME_WORDS);
  - an enum-free pad-region predicate function, reused by the verification model.
- One natural sub-module: fmpad_output_stage. It contains the 1-deep AXI-stream register with slot_free, load and O_valid logic. The top level contains the counters and the pad decode.

## Test plan
- Defaults, sink ready, source always valid, input data = word index.
  - Exactly 1872 output words per frame; outputs 0–168 are zero.
  - Output 169 carries input word 0; output 181 carries input word 12.
  - Outputs 1716–1871 are zero; in0_V_V_TREADY asserts exactly 1300 cycles per frame.
- Sink throttled 1-in-3 ready:
  - output sequence is identical to the first scenario;
  - no word is dropped or duplicated;
  - TDATA is stable during every stall.
- Source valid deasserted for 20 cycles at input word 500:
  - output pauses at the matching interior position;
  - pad words preceding that position are still emitted;
  - no bubble occurs after resume.
- Three back-to-back frames with continuous ready/valid:
  - 5616 outputs in 5617 cycles after reset release;
  - frame 2 output 169 equals frame 2 input word 0.
- Reset asserted asynchronously at output word 900, released 3 cycles later:
  - TVALID=0 and TREADY=0 immediately on assertion;
  - after release, outputs restart at frame word 0 (169 zeros, then the new input word 0).
- PAD_* = 0, IMG 4×4, FOLD 2: output equals input delayed by 1 cycle, with 32 words per frame.
